// File: rtl/kbd_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key-code width, matrix size,
// debounce FSM state encodings and the per-frame press-map classifier.
package kbd_scan_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int KBD_COLS   = 4;
  localparam int KBD_ROWS   = 4;
  localparam int KEY_MAP_W  = KBD_COLS * KBD_ROWS;
  localparam int COL_IDX_W  = $clog2(KBD_COLS);

  // All columns released (active-low strobes)
  localparam logic [KBD_COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kbd_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_cls_e;

  typedef struct packed {
    frame_cls_e              cls;
    logic [KEY_CODE_W-1:0]   code;
  } frame_info_t;

  // Reduce a full-frame press map to none / single key (with its code) / multi
  function automatic frame_info_t classify_frame(input logic [KEY_MAP_W-1:0] map);
    frame_info_t info;
    int unsigned hits;
    info.cls  = FR_NONE;
    info.code = '0;
    hits      = 0;
    for (int i = 0; i < KEY_MAP_W; i++) begin
      if (map[i]) begin
        hits++;
        info.code = KEY_CODE_W'(i);
      end
    end
    if (hits == 1) begin
      info.cls = FR_SINGLE;
    end else if (hits > 1) begin
      info.cls = FR_MULTI;
    end
    return info;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous key-code FIFO. The head entry and its valid flag are
// registered so the CPU sees a stable code; a pop exposes the next entry on
// the following cycle. A push into a full FIFO is only accepted together with
// a pop; a pop of an empty FIFO is ignored. DEPTH must be a power of 2.
module kbd_fifo
  import kbd_scan_pkg::*;
#(
  parameter int WIDTH = KEY_CODE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      remaining;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;
  assign valid_o = valid_q;

  // Next pointers, occupancy and the head entry as it will look after this cycle
  always_comb begin
    pop_en    = pop_i && !empty_o;
    push_en   = push_i && (!full_o || pop_en);
    wr_ptr_d  = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    remaining = count_q - (AW+1)'(pop_en);
    // With nothing left after the pop, the head is the incoming code (if any)
    if (remaining == '0) begin
      head_d = push_en ? din_i : '0;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    valid_d = (count_d != '0);
  end

  // Storage array; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/kbd_scan.sv
// 4x4 matrix keypad scanner: active-low column strobes, active-low row
// returns, per-frame single-key debounce FSM and a key-code FIFO read by the
// CPU. Optional auto-repeat of a held key is enabled by defining
// KBD_AUTOREPEAT_EN.
module kbd_scan
  import kbd_scan_pkg::*;
#(
  parameter int SCAN_DIV        = 2499,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_FRAMES   = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KBD_ROWS-1:0] row_i,
  input  logic                rd_i,
  output logic [KBD_COLS-1:0] col_o,
  output logic [31:0]         data_o,
  output logic                key_valid_o,
  output logic                overflow_o
);

  localparam int              DIV_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [3:0]      DB_LAST = 4'(DEBOUNCE_FRAMES);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
    $error("kbd_scan: DEBOUNCE_FRAMES must be in 1..15");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("kbd_scan: FIFO_DEPTH must be at least 2");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("kbd_scan: REPEAT_FRAMES must be at least 1");
  end

  logic [DIV_W-1:0]     div_q, div_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic [KBD_COLS-1:0]  col_q, col_d;
  logic [KEY_MAP_W-1:0] map_q, map_d;
  logic                 col_last;
  logic                 frame_end;

  frame_info_t          info;
  logic                 is_single, is_none, same_key;

  kbd_state_e            state_q;
  logic [KEY_CODE_W-1:0] cand_q;
  logic [3:0]            cnt_q;
  logic                  push;

  logic                  fifo_full, fifo_empty;
  logic [KEY_CODE_W-1:0] fifo_head;
  logic                  fifo_valid;
  logic                  drop;
  logic                  overflow_q, overflow_d;

`ifdef KBD_AUTOREPEAT_EN
  localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);
  logic [REP_W-1:0]          rep_q;
`endif

  // Column dwell counter, strobe pattern and press-map capture on each column's last cycle
  always_comb begin
    col_last  = (div_q == DIV_W'(SCAN_DIV));
    frame_end = col_last && (col_idx_q == COL_IDX_W'(KBD_COLS - 1));
    div_d     = col_last ? '0 : div_q + DIV_W'(1);
    col_idx_d = col_last ? col_idx_q + COL_IDX_W'(1) : col_idx_q;
    col_d     = COL_IDLE ^ (KBD_COLS'(1) << col_idx_d);
    map_d     = map_q;
    if (col_last) begin
      for (int r = 0; r < KBD_ROWS; r++) begin
        map_d[r*KBD_COLS + int'(col_idx_q)] = ~row_i[r];
      end
    end
  end

  // Scanner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= '0;
      col_q     <= COL_IDLE ^ KBD_COLS'(1);
      map_q     <= '0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      map_q     <= map_d;
    end
  end

  // Classify the completed frame (column 3 merged in this cycle) and decide on a push
  always_comb begin
    info      = classify_frame(map_d);
    is_single = (info.cls == FR_SINGLE);
    is_none   = (info.cls == FR_NONE);
    same_key  = is_single && (info.code == cand_q);
    push      = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE:     push = is_single && (DEBOUNCE_FRAMES == 1);
        ST_DEBOUNCE: push = same_key && ((cnt_q + 4'd1) == DB_LAST);
`ifdef KBD_AUTOREPEAT_EN
        ST_HELD:     push = same_key && ((rep_q + REP_W'(1)) == REP_LAST);
`endif
        default:     push = 1'b0;
      endcase
    end
  end

  // Debounce FSM, stepped once per frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
`ifdef KBD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_q <= info.code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_DEBOUNCE;
              cnt_q   <= 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (same_key) begin
            if ((cnt_q + 4'd1) == DB_LAST) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else if (is_single) begin
            cand_q <= info.code;
            cnt_q  <= 4'd1;
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        ST_HELD: begin
          // A different key while held is ignored until a release is accepted
          if (is_none) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_RELEASE;
              cnt_q   <= 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (is_none) begin
            if ((cnt_q + 4'd1) == DB_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
`ifdef KBD_AUTOREPEAT_EN
      // Repeat counter only runs while the same key stays alone in HELD
      if (state_q == ST_HELD && same_key) begin
        rep_q <= push ? '0 : rep_q + REP_W'(1);
      end else begin
        rep_q <= '0;
      end
`endif
    end
  end

  kbd_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (info.code),
    .pop_i   (rd_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .valid_o (fifo_valid)
  );

  // A push is lost only when the FIFO is full and no pop frees a slot this cycle
  always_comb begin
    drop       = push && fifo_full && !(rd_i && !fifo_empty);
    overflow_d = overflow_q || drop;
  end

  // Sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign col_o       = col_q;
  assign data_o      = {{(32-KEY_CODE_W){1'b0}}, fifo_head};
  assign key_valid_o = fifo_valid;
  assign overflow_o  = overflow_q;

endmodule
